// File: rtl/vc_val_rdy_to_val_credit_multi_adapter_if.sv
// Bundle of the per-channel valid/ready inputs, the credited link output and the credit bookkeeping
// outputs of the multi-channel val/rdy to val/credit adapter.
interface vc_val_rdy_to_val_credit_multi_adapter_if #(
    parameter int MSG_SZ          = 32,
    parameter int NUM_CHAN        = 2,
    parameter int CHAN_SZ         = 1,
    parameter int CREDIT_COUNT_SZ = 3
);
    logic [NUM_CHAN*MSG_SZ-1:0]          i_msg;
    logic [NUM_CHAN-1:0]                 i_val;
    logic [NUM_CHAN-1:0]                 o_rdy;
    logic [MSG_SZ-1:0]                   o_msg;
    logic [CHAN_SZ-1:0]                  o_chan;
    logic                                o_val;
    logic [NUM_CHAN-1:0]                 i_credit;
    logic [NUM_CHAN*CREDIT_COUNT_SZ-1:0] o_credit_count;
    logic                                o_overflow;

    // Master is the environment: it offers messages and returns credits.
    modport master (
        output i_msg, i_val, i_credit,
        input  o_rdy, o_msg, o_chan, o_val, o_credit_count, o_overflow
    );

    modport slave (
        input  i_msg, i_val, i_credit,
        output o_rdy, o_msg, o_chan, o_val, o_credit_count, o_overflow
    );
endinterface

// File: rtl/vc_val_rdy_to_val_credit_multi_adapter.sv
// Multiplexes NUM_CHAN val/rdy input channels onto one registered val/credit link, with a
// round-robin arbiter and per-channel credit counters guarding each virtual channel.
module vc_val_rdy_to_val_credit_multi_adapter #(
    parameter int MSG_SZ           = 32,
    parameter int NUM_CHAN         = 2,
    parameter int CHAN_SZ          = 1,
    parameter int MAX_CREDIT_COUNT = 4,
    parameter int CREDIT_COUNT_SZ  = 3
) (
    input  logic clk,
    input  logic reset,
    vc_val_rdy_to_val_credit_multi_adapter_if.slave bus
);
    localparam logic [CREDIT_COUNT_SZ-1:0] MAX_CNT   = CREDIT_COUNT_SZ'(MAX_CREDIT_COUNT);
    localparam logic [CHAN_SZ-1:0]         LAST_CHAN = CHAN_SZ'(NUM_CHAN - 1);

    logic [NUM_CHAN-1:0] eligible;
    logic [NUM_CHAN-1:0] above_ptr;
    logic [NUM_CHAN-1:0] hi_req;
    logic [NUM_CHAN-1:0] req;
    logic [NUM_CHAN-1:0] grant;
    logic [NUM_CHAN-1:0] ovf_hit;
    logic [CHAN_SZ-1:0]  grant_idx;
    logic                any_grant;

    logic [CHAN_SZ-1:0]  ptr_q,  ptr_d;
    logic [MSG_SZ-1:0]   msg_q,  msg_d;
    logic [CHAN_SZ-1:0]  chan_q, chan_d;
    logic                val_q,  val_d;
    logic                ovf_q,  ovf_d;

    // Per-channel eligibility, priority mask and credit counter.
    for (genvar gi = 0; gi < NUM_CHAN; gi++) begin : g_chan
        logic [CREDIT_COUNT_SZ-1:0] cnt_q, cnt_d;
        logic                       ovf_c;

        assign eligible[gi]  = bus.i_val[gi] && (cnt_q != '0);
        assign above_ptr[gi] = (CHAN_SZ'(gi) >= ptr_q);

        // A send and a returned credit in the same cycle cancel out.
        always_comb begin
            cnt_d = cnt_q;
            ovf_c = 1'b0;
            if (grant[gi] && !bus.i_credit[gi]) begin
                cnt_d = cnt_q - CREDIT_COUNT_SZ'(1);
            end else if (!grant[gi] && bus.i_credit[gi]) begin
                if (cnt_q == MAX_CNT) begin
                    ovf_c = 1'b1;
                end else begin
                    cnt_d = cnt_q + CREDIT_COUNT_SZ'(1);
                end
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt_q <= MAX_CNT;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign ovf_hit[gi] = ovf_c;
        assign bus.o_credit_count[gi*CREDIT_COUNT_SZ +: CREDIT_COUNT_SZ] = cnt_q;
        assign bus.o_rdy[gi] = grant[gi];
    end

    // Round robin: prefer requesters at or above ptr, otherwise wrap to the lowest requester.
    always_comb begin
        hi_req    = eligible & above_ptr;
        req       = (hi_req != '0) ? hi_req : eligible;
        grant     = req & (~req + NUM_CHAN'(1));
        any_grant = |req;
        grant_idx = '0;
        for (int i = 0; i < NUM_CHAN; i++) begin
            if (grant[i]) begin
                grant_idx = CHAN_SZ'(i);
            end
        end
    end

    always_comb begin
        msg_d  = msg_q;
        chan_d = chan_q;
        ptr_d  = ptr_q;
        val_d  = any_grant;
        ovf_d  = ovf_q | (|ovf_hit);
        for (int i = 0; i < NUM_CHAN; i++) begin
            if (grant[i]) begin
                msg_d = bus.i_msg[i*MSG_SZ +: MSG_SZ];
            end
        end
        if (any_grant) begin
            chan_d = grant_idx;
            ptr_d  = (grant_idx == LAST_CHAN) ? '0 : grant_idx + CHAN_SZ'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q  <= '0;
            msg_q  <= '0;
            chan_q <= '0;
            val_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            msg_q  <= msg_d;
            chan_q <= chan_d;
            val_q  <= val_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bus.o_msg      = msg_q;
    assign bus.o_chan     = chan_q;
    assign bus.o_val      = val_q;
    assign bus.o_overflow = ovf_q;

endmodule

// File: tb/tb_vc_val_rdy_to_val_credit_multi_adapter.sv
// Randomised and directed bench for the multi-channel val/rdy to val/credit adapter, scored against
// a queue-free behavioural model of arbitration and credit accounting.
module tb_vc_val_rdy_to_val_credit_multi_adapter;
    localparam int MSG_SZ  = 32;
    localparam int NCH     = 2;
    localparam int CHSZ    = 1;
    localparam int MAXC    = 4;
    localparam int CSZ     = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    vc_val_rdy_to_val_credit_multi_adapter_if #(
        .MSG_SZ(MSG_SZ), .NUM_CHAN(NCH), .CHAN_SZ(CHSZ), .CREDIT_COUNT_SZ(CSZ)
    ) bus ();

    vc_val_rdy_to_val_credit_multi_adapter #(
        .MSG_SZ(MSG_SZ), .NUM_CHAN(NCH), .CHAN_SZ(CHSZ),
        .MAX_CREDIT_COUNT(MAXC), .CREDIT_COUNT_SZ(CSZ)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int check_cnt = 0;
    int err_cnt   = 0;

    int          m_cnt [NCH];
    int          m_ptr;
    bit          m_val;
    logic [31:0] m_msg;
    int          m_chan;
    bit          m_ovf;
    int          last_grant;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        check_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) m_cnt[c] = MAXC;
        m_ptr = 0; m_val = 0; m_msg = '0; m_chan = 0; m_ovf = 0; last_grant = -1;
    endtask

    function automatic int model_pick();
        for (int k = 0; k < NCH; k++) begin
            int c;
            c = (m_ptr + k) % NCH;
            if (bus.i_val[c] && m_cnt[c] > 0) return c;
        end
        return -1;
    endfunction

    task automatic check_outputs(input string tag);
        for (int c = 0; c < NCH; c++)
            check_val($sformatf("%s_cnt%0d", tag, c), 64'(bus.o_credit_count[c*CSZ +: CSZ]), 64'(m_cnt[c]));
        check_val({tag, "_val"},  64'(bus.o_val),      64'(m_val));
        check_val({tag, "_msg"},  64'(bus.o_msg),      64'(m_msg));
        check_val({tag, "_chan"}, 64'(bus.o_chan),     64'(m_chan));
        check_val({tag, "_ovf"},  64'(bus.o_overflow), 64'(m_ovf));
    endtask

    // One clock cycle: check ready against the model's grant, clock, advance model, check registers.
    task automatic step(input string tag);
        int              g;
        logic [NCH-1:0]  exp_rdy;
        logic [NCH-1:0]  crd;
        logic [31:0]     sent;
        #1;
        g = model_pick();
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check_val({tag, "_rdy"}, 64'(bus.o_rdy), 64'(exp_rdy));
        sent = (g >= 0) ? bus.i_msg[g*MSG_SZ +: MSG_SZ] : '0;
        crd  = bus.i_credit;
        @(posedge clk);
        for (int c = 0; c < NCH; c++) begin
            if (c == g && !crd[c]) m_cnt[c]--;
            else if (c != g && crd[c]) begin
                if (m_cnt[c] == MAXC) m_ovf = 1;
                else m_cnt[c]++;
            end
        end
        if (g >= 0) begin
            m_val = 1; m_msg = sent; m_chan = g; m_ptr = (g + 1) % NCH;
            $display("%s: xfer ch%0d msg=%08h cnt0=%0d cnt1=%0d", tag, g, sent, m_cnt[0], m_cnt[1]);
        end else begin
            m_val = 0;
        end
        last_grant = g;
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset();
        bus.i_val = '0; bus.i_credit = '0; bus.i_msg = '0;
        reset = 1'b0;
        #1;
        model_reset();
        check_outputs("rst");
        check_val("rst_rdy", 64'(bus.o_rdy), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic rand_msgs();
        for (int c = 0; c < NCH; c++) bus.i_msg[c*MSG_SZ +: MSG_SZ] = $urandom;
    endtask

    initial begin
        int n_xfer;
        int n_val;

        do_reset();

        // Single-channel drain
        n_xfer = 0; n_val = 0;
        bus.i_val = 2'b01;
        for (int k = 0; k < 6; k++) begin
            rand_msgs();
            step("drain");
            if (last_grant == 0) n_xfer++;
            if (bus.o_val) n_val++;
        end
        #1;
        check_val("drain_xfers", 64'(n_xfer), 64'(4));
        check_val("drain_oval_cycles", 64'(n_val), 64'(4));
        check_val("drain_rdy0", 64'(bus.o_rdy[0]), 64'(0));
        check_val("drain_cnt0", 64'(bus.o_credit_count[0 +: CSZ]), 64'(0));

        // Round robin with each sent credit returned the following cycle
        do_reset();
        bus.i_val = 2'b11;
        for (int k = 0; k < 6; k++) begin
            rand_msgs();
            step("rr");
            check_val($sformatf("rr_chan%0d", k), 64'(bus.o_chan), 64'(k % 2));
            bus.i_credit = '0;
            if (last_grant >= 0) bus.i_credit[last_grant] = 1'b1;
        end

        // Simultaneous credit and send
        do_reset();
        bus.i_val = 2'b01;
        for (int k = 0; k < 2; k++) begin rand_msgs(); step("sim"); end
        bus.i_credit = 2'b01;
        rand_msgs();
        step("sim");
        check_val("sim_cnt0", 64'(bus.o_credit_count[0 +: CSZ]), 64'(2));
        check_val("sim_oval", 64'(bus.o_val), 64'(1));

        // Overflow is sticky
        do_reset();
        bus.i_credit = 2'b10;
        step("ovf");
        check_val("ovf_cnt1", 64'(bus.o_credit_count[CSZ +: CSZ]), 64'(MAXC));
        check_val("ovf_flag", 64'(bus.o_overflow), 64'(1));
        bus.i_credit = '0;
        for (int k = 0; k < 3; k++) step("ovf_hold");
        check_val("ovf_sticky", 64'(bus.o_overflow), 64'(1));

        // Starved channel
        do_reset();
        bus.i_val = 2'b10;
        for (int k = 0; k < 4; k++) begin rand_msgs(); step("starve_fill"); end
        bus.i_val = 2'b11;
        for (int k = 0; k < 3; k++) begin
            rand_msgs();
            step("starve");
            check_val("starve_chan", 64'(bus.o_chan), 64'(0));
        end
        bus.i_credit = 2'b10;
        rand_msgs();
        step("starve_crd");
        bus.i_credit = '0;
        rand_msgs();
        step("starve_wake");
        check_val("starve_wake_chan", 64'(bus.o_chan), 64'(1));

        // Asynchronous reset between edges with a message in flight
        do_reset();
        bus.i_val = 2'b01;
        for (int k = 0; k < 3; k++) begin rand_msgs(); step("arst_pre"); end
        check_val("arst_pre_val", 64'(bus.o_val), 64'(1));
        #2;
        reset = 1'b0;
        #1;
        check_val("arst_oval", 64'(bus.o_val), 64'(0));
        check_val("arst_cnt0", 64'(bus.o_credit_count[0 +: CSZ]), 64'(MAXC));
        model_reset();
        check_outputs("arst");
        bus.i_val = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Randomised traffic, with a reset partway through
        for (int k = 0; k < 400; k++) begin
            if (k == 200) do_reset();
            bus.i_val = NCH'($urandom);
            for (int c = 0; c < NCH; c++) bus.i_credit[c] = ($urandom_range(0, 3) == 0);
            rand_msgs();
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/vc_val_rdy_to_val_credit_multi_adapter.md
VC_VAL_RDY_TO_VAL_CREDIT_MULTI_ADAPTER -- requirements
Module: vc_val_rdy_to_val_credit_multi_adapter

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
  MSG_SZ  32  message width
  NUM_CHAN  2  number of input channels (virtual channels), 1..16
  CHAN_SZ  1  channel-id width, >= clog2(NUM_CHAN), minimum 1
  MAX_CREDIT_COUNT  4  credits per channel at reset
  CREDIT_COUNT_SZ  3  counter width, must hold MAX_CREDIT_COUNT
REQ-002 Ports SHALL be, as name, direction, width, meaning:
  clk  input  1  clock
  reset  input  1  asynchronous active-low reset
  i_msg  input  NUM_CHAN*MSG_SZ  per-channel messages; channel c at bits [c*MSG_SZ +: MSG_SZ]
  i_val  input  NUM_CHAN  per-channel valid
  o_rdy  output  NUM_CHAN  per-channel ready
  o_msg  output  MSG_SZ  link message, registered
  o_chan  output  CHAN_SZ  channel id of o_msg, registered
  o_val  output  1  link valid, registered
  i_credit  input  NUM_CHAN  per-channel credit return, one credit per asserted bit per cycle
  o_credit_count  output  NUM_CHAN*CREDIT_COUNT_SZ  live per-channel credit counts
  o_overflow  output  1  sticky credit-overflow error flag
REQ-003 The clock SHALL be clk only, and reset SHALL be asynchronous and active-low (asserted when reset = 0).

Function
REQ-004 Channel c SHALL be eligible in a cycle iff i_val[c] = 1 and count[c] != 0.
REQ-005 A round-robin arbiter SHALL grant at most one eligible channel per cycle, searching upward (with wrap) from priority pointer ptr.
REQ-006 o_rdy[c] SHALL equal grant[c]; o_rdy may depend combinationally on i_val and the counts, and SHALL be 0 for every channel with count 0.
REQ-007 A transfer on channel c SHALL occur when i_val[c] & o_rdy[c] = 1.
REQ-008 On a transfer, the next clock edge SHALL load o_msg with the channel-c message, o_chan with c, and o_val with 1, giving exactly one cycle of latency.
REQ-009 In any cycle with no transfer, the next edge SHALL set o_val to 0 and hold o_msg and o_chan.
REQ-010 After a transfer on channel g, ptr SHALL become (g+1) mod NUM_CHAN; with no transfer, ptr SHALL hold.
REQ-011 Per channel, each clock edge SHALL update count[c] as follows:
  transfer only: count[c] - 1
  i_credit[c] only: count[c] + 1
  both in the same cycle: count[c] unchanged
  neither: count[c] unchanged
REQ-012 i_credit[c] = 1 while count[c] = MAX_CREDIT_COUNT with no transfer on c SHALL leave count[c] at MAX_CREDIT_COUNT (saturate) and set o_overflow to 1.
REQ-013 o_overflow SHALL stay 1 until reset.
REQ-014 A count SHALL never go below 0, which REQ-004 guarantees.
REQ-015 Credit returns on multiple channels in one cycle SHALL all be applied in that cycle.
REQ-016 o_credit_count SHALL show the registered count values, not next-state values.
REQ-017 With NUM_CHAN = 1 the arbiter SHALL degenerate to "grant = eligible", and o_chan SHALL be constant 0.

Reset
REQ-018 While reset = 0, all outputs SHALL take their reset values immediately, without waiting for clk:
  every count = MAX_CREDIT_COUNT
  ptr = 0
  o_val = 0, o_msg = 0, o_chan = 0
  o_overflow = 0
REQ-019 Reset asserted mid-operation SHALL discard the in-flight registered message and restore full credits.
REQ-020 The first clock edge after reset deasserts SHALL behave as a normal cycle.

Verification
REQ-021 The bench SHALL cover the following scenarios (defaults: NUM_CHAN = 2, MAX_CREDIT_COUNT = 4):
  Single-channel drain: ch0 valid for 6 cycles, no credits -> 4 transfers; o_rdy[0] = 0 after the 4th; count0 = 0; o_val high for 4 cycles, each lagging its transfer by one cycle.
  Round-robin: both channels valid continuously with credits refilled every cycle -> o_chan alternates 0,1,0,1 starting at 0 after reset.
  Simultaneous credit and send: count0 = 2, transfer on ch0 and i_credit[0] in the same cycle -> count0 stays 2.
  Overflow: idle after reset, i_credit[1] pulsed -> count1 stays 4, o_overflow = 1, and it remains 1 for later cycles.
  Starved channel: count1 = 0, both channels valid -> ch0 granted every cycle, o_rdy[1] = 0; after one i_credit[1], ch1 is granted in the next cycle.
  Async reset: reset driven low between clock edges while o_val = 1 and count0 = 1 -> o_val = 0 and count0 = 4 immediately, before the next clk edge.
